// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the Goldschmidt divider controller and datapath.
// Optional feature macro: FPDIV_ROUND_EN (adds the RND correction state).
package fpdiv_pkg;

    // Controller states; RND exists only when the rounding pass is built in.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_Q0   = 3'd1,
        ST_D0   = 3'd2,
        ST_QI   = 3'd3,
        ST_DI   = 3'd4,
`ifdef FPDIV_ROUND_EN
        ST_RND  = 3'd5,
`endif
        ST_DONE = 3'd6
    } state_t;

    // Mux A selects (2'b11 is never driven).
    localparam logic [1:0] SELA_REGA = 2'b00;
    localparam logic [1:0] SELA_D    = 2'b01;
    localparam logic [1:0] SELA_IA   = 2'b10;

    // Mux B selects.
    localparam logic [1:0] SELB_D    = 2'b00;
    localparam logic [1:0] SELB_X    = 2'b01;
    localparam logic [1:0] SELB_REGB = 2'b10;
    localparam logic [1:0] SELB_REGC = 2'b11;

    // True for states in which the divider is working on an operand.
    function automatic logic state_is_busy(input state_t s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/fpdiv_ctrl_if.sv
// Handshake and datapath-control bundle between a requester, the divider
// controller and the fpdiv datapath.
// Optional feature macro: FPDIV_ROUND_EN (no interface change).
interface fpdiv_ctrl_if;
    logic       start;
    logic [1:0] sel_muxa;
    logic [1:0] sel_muxb;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       busy;
    logic       done;

    // Requester side: issues start, observes status and controls.
    modport master (
        output start,
        input  sel_muxa, sel_muxb, loada, loadb, loadc, busy, done
    );

    // Controller side: consumes start, drives status and controls.
    modport slave (
        input  start,
        output sel_muxa, sel_muxb, loada, loadb, loadc, busy, done
    );
endinterface

// File: rtl/fpdiv_ctrl.sv
// Goldschmidt divide sequencer: steps the shared multiplier through
// Q0 = IA*x, D0 = IA*d, then ITERS refinement passes Q <= K*Q / D <= K*D.
// All outputs are decoded from the state register only.
// Optional feature macro: FPDIV_ROUND_EN (one extra RND pass before DONE).
// ITERS must lie in 1..7 so the 3-bit iteration counter never wraps.
module fpdiv_ctrl
    import fpdiv_pkg::*;
#(
    parameter int unsigned ITERS = 3
) (
    input  logic         clk,
    input  logic         reset,
    fpdiv_ctrl_if.slave  bus
);

    localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] iter_cnt;
    logic [2:0] iter_cnt_next;

    // State and iteration counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            iter_cnt <= 3'd0;
        end else begin
            state    <= state_next;
            iter_cnt <= iter_cnt_next;
        end
    end

    // Next-state, counter update and Moore output decode.
    always_comb begin
        state_next    = state;
        iter_cnt_next = iter_cnt;
        bus.sel_muxa  = SELA_REGA;
        bus.sel_muxb  = SELB_D;
        bus.loada     = 1'b0;
        bus.loadb     = 1'b0;
        bus.loadc     = 1'b0;
        bus.busy      = state_is_busy(state);
        bus.done      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_Q0;
                end
            end

            ST_Q0: begin
                bus.sel_muxa = SELA_IA;
                bus.sel_muxb = SELB_X;
                bus.loadc    = 1'b1;
                state_next   = ST_D0;
            end

            ST_D0: begin
                bus.sel_muxa  = SELA_IA;
                bus.sel_muxb  = SELB_D;
                bus.loada     = 1'b1;
                bus.loadb     = 1'b1;
                iter_cnt_next = 3'd0;
                state_next    = ST_QI;
            end

            ST_QI: begin
                bus.sel_muxa = SELA_REGA;
                bus.sel_muxb = SELB_REGC;
                bus.loadc    = 1'b1;
                if (iter_cnt == LAST_ITER) begin
`ifdef FPDIV_ROUND_EN
                    state_next = ST_RND;
`else
                    state_next = ST_DONE;
`endif
                end else begin
                    state_next = ST_DI;
                end
            end

            ST_DI: begin
                bus.sel_muxa  = SELA_REGA;
                bus.sel_muxb  = SELB_REGB;
                bus.loada     = 1'b1;
                bus.loadb     = 1'b1;
                iter_cnt_next = iter_cnt + 3'd1;
                state_next    = ST_QI;
            end

`ifdef FPDIV_ROUND_EN
            ST_RND: begin
                bus.sel_muxa = SELA_REGA;
                bus.sel_muxb = SELB_REGC;
                bus.loadc    = 1'b1;
                state_next   = ST_DONE;
            end
`endif

            ST_DONE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    state_next = ST_Q0;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed bench for fpdiv_ctrl: one instance with ITERS=3 and one with
// ITERS=1, checked cycle by cycle against hand-written control words.
// Optional feature macro: FPDIV_ROUND_EN (expected sequences gain RND).
module tb_fpdiv_ctrl;

    // Control word layout: {sel_muxa, sel_muxb, loada, loadb, loadc, busy, done}
    localparam logic [8:0] W_IDLE = 9'b00_00_000_00;
    localparam logic [8:0] W_Q0   = 9'b10_01_001_10;
    localparam logic [8:0] W_D0   = 9'b10_00_110_10;
    localparam logic [8:0] W_QI   = 9'b00_11_001_10;
    localparam logic [8:0] W_DI   = 9'b00_10_110_10;
    localparam logic [8:0] W_RND  = 9'b00_11_001_10;
    localparam logic [8:0] W_DONE = 9'b00_00_000_01;

    logic clk;
    logic reset;

    fpdiv_ctrl_if if3 ();
    fpdiv_ctrl_if if1 ();

    fpdiv_ctrl #(.ITERS(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));
    fpdiv_ctrl #(.ITERS(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    logic [8:0] word3;
    logic [8:0] word1;
    assign word3 = {if3.sel_muxa, if3.sel_muxb, if3.loada, if3.loadb, if3.loadc, if3.busy, if3.done};
    assign word1 = {if1.sel_muxa, if1.sel_muxb, if1.loada, if1.loadb, if1.loadc, if1.busy, if1.done};

    int checks;
    int errors;
    logic [8:0] seq3[$];
    logic [8:0] seq1[$];

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    function automatic logic [8:0] obs(input int which);
        return (which == 3) ? word3 : word1;
    endfunction

    // Caller has just ticked into cycle 1 of a divide; checks every cycle
    // through DONE, leaving the bench in the DONE cycle.
    task automatic expect_seq(input int which, input string tag);
        int n;
        n = (which == 3) ? seq3.size() : seq1.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            check($sformatf("%s_c%0d", tag, i + 1), obs(which),
                  (which == 3) ? seq3[i] : seq1[i]);
        end
    endtask

    initial begin
        int done_cnt;
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        if3.start  = 1'b0;
        if1.start  = 1'b0;

        seq3 = '{W_Q0, W_D0, W_QI, W_DI, W_QI, W_DI, W_QI};
        seq1 = '{W_Q0, W_D0, W_QI};
`ifdef FPDIV_ROUND_EN
        seq3.push_back(W_RND);
        seq1.push_back(W_RND);
`endif
        seq3.push_back(W_DONE);
        seq1.push_back(W_DONE);

        // Reset state, including reset overriding start.
        tick();
        if3.start = 1'b1;
        tick();
        check("reset_idle_3", word3, W_IDLE);
        check("reset_idle_1", word1, W_IDLE);
        if3.start = 1'b0;
        reset = 1'b0;
        tick();
        check("idle_hold_3", word3, W_IDLE);

        // Single-pulse divide, ITERS=3.
        if3.start = 1'b1;
        tick();
        if3.start = 1'b0;
        expect_seq(3, "iters3");
        tick();
        check("iters3_after", word3, W_IDLE);

        // Single-pulse divide, ITERS=1: no DI.
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        expect_seq(1, "iters1");
        tick();
        check("iters1_after", word1, W_IDLE);

        // start held high: back-to-back divides with no idle gap.
        if3.start = 1'b1;
        tick();
        expect_seq(3, "b2b_first");
        tick();
        expect_seq(3, "b2b_second");
        if3.start = 1'b0;
        tick();
        check("b2b_after", word3, W_IDLE);

        // start pulsed in cycles 2 and 5 is ignored; exactly one done.
        done_cnt = 0;
        if3.start = 1'b1;
        tick();
        if3.start = 1'b0;
        for (int k = 1; k <= seq3.size() + 4; k++) begin
            if (k > 1) tick();
            if (k <= seq3.size())
                check($sformatf("ignore_c%0d", k), word3, seq3[k-1]);
            if (if3.done) done_cnt++;
            if3.start = (k == 2 || k == 5);
        end
        check("ignore_done_count", 9'(done_cnt), 9'd1);
        check("ignore_after", word3, W_IDLE);

        // Reset in cycle 4 aborts; then a fresh divide completes.
        if3.start = 1'b1;
        tick();
        if3.start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick();
            check($sformatf("abort_c%0d", k), word3, seq3[k-1]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_idle", word3, W_IDLE);
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (if3.done) done_cnt++;
        end
        check("abort_no_done", 9'(done_cnt), 9'd0);
        check("abort_still_idle", word3, W_IDLE);
        if3.start = 1'b1;
        tick();
        if3.start = 1'b0;
        expect_seq(3, "fresh");
        tick();
        check("fresh_after", word3, W_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpdiv_ctrl.md
FPDIV_CTRL -- requirements
Module: fpdiv_ctrl

Interface
REQ-001 Parameter ITERS, default 3, number of Goldschmidt quotient-refinement (QI) steps; legal range 1..7.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a divide; sampled only in IDLE or DONE.
REQ-005 sel_muxa  output  2  datapath mux A select: 00=rega (K), 01=d, 10=IA constant, 11 never driven.
REQ-006 sel_muxb  output  2  datapath mux B select: 00=d, 01=x, 10=regb (D_i), 11=regc (Q_i).
REQ-007 loada  output  1  capture K = ones-complement of product into rega.
REQ-008 loadb  output  1  capture product into regb (divisor track D_i).
REQ-009 loadc  output  1  capture product into regc (quotient track Q_i).
REQ-010 busy  output  1  high in every state except IDLE and DONE.
REQ-011 done  output  1  single-cycle pulse; regc holds final quotient in that cycle.

Function
REQ-012 States: IDLE, Q0, D0, QI, DI, RND (only with macro), DONE; one-hot or binary encoding is implementation choice.
REQ-013 All outputs Moore-decoded from state register only; no start-to-output combinational path.
REQ-014 IDLE: sel_muxa=00, sel_muxb=00, loads=0, busy=0, done=0; start=1 -> Q0, else stay.
REQ-015 Q0: sel_muxa=10, sel_muxb=01, loadc=1 (Q_0 = IA*x); -> D0.
REQ-016 D0: sel_muxa=10, sel_muxb=00, loada=1, loadb=1 (D_0 = IA*d, K = ~D_0); clear iter_cnt; -> QI.
REQ-017 QI: sel_muxa=00, sel_muxb=11, loadc=1 (Q_i+1 = K*Q_i); if iter_cnt==ITERS-1 -> DONE (or RND), else -> DI.
REQ-018 DI: sel_muxa=00, sel_muxb=10, loada=1, loadb=1 (D_i+1 = K*D_i, K = ~D_i+1); iter_cnt+1; -> QI.
REQ-019 DONE: done=1, busy=0, loads=0, selects=00; start=1 -> Q0 (back-to-back), else -> IDLE.
REQ-020 Active cycles per divide = 2*ITERS+1 (+1 with RND); done asserted in cycle 2*ITERS+2 after start sampled (ITERS=3: cycle 8).
REQ-021 start while busy is ignored; no queuing, no error flag.
REQ-022 At most one of loada/loadc with loadb pairing as above; loadc never coincides with loadb.
REQ-023 iter_cnt 3 bits, never wraps; value outside QI/DI is don't-care but deterministic (held).

Reset
REQ-024 reset=1 at any edge forces IDLE, iter_cnt=0, all outputs to IDLE values next cycle, overriding start.
REQ-025 Reset mid-divide aborts with no done pulse; no loads asserted in the cycle after reset.

Configuration
REQ-026 Macro FPDIV_ROUND_EN: when defined, QI final exit goes to RND, where sel_muxa=00, sel_muxb=11, loadc=1 (final RNE correction pass), then DONE; latency +1.
REQ-027 Without FPDIV_ROUND_EN, RND state and its decode are absent; QI final exit goes directly to DONE.

Structure
REQ-028 Package fpdiv_pkg holds state enum, mux select constants (SELA_REGA/D/IA, SELB_D/X/REGB/REGC), shared with the fpdiv datapath.
REQ-029 Single module; no sub-module needed (counter and decode inline), target 120-250 lines.

Verification
REQ-030 Reset, ITERS=3, start pulse 1 cycle -> Q0,D0,QI,DI,QI,DI,QI, done in cycle 8, busy cycles 1-7, exact select/load pattern per REQ-015..018.
REQ-031 ITERS=1 -> Q0,D0,QI, done in cycle 4; DI never entered.
REQ-032 start held high continuously -> divides back-to-back, done every 8 cycles (ITERS=3), no IDLE cycle between.
REQ-033 start pulsed in cycles 2 and 5 of a divide -> ignored; exactly one done.
REQ-034 reset asserted in cycle 4 of divide -> IDLE next cycle, all loads 0, no done; fresh start then completes normally.
REQ-035 FPDIV_ROUND_EN defined, ITERS=3 -> RND in cycle 8 with loadc=1, sel 00/11, done in cycle 9.
